// File: rtl/video_vram_arbiter_pkg.sv
// video_vram_types: shared types for the VRAM arbiter slice.
//   vram_state_t : bus sequencer states (IDLE -> ACCESS -> [CAPTURE] -> IDLE)
//   grant_t      : owner of the current bus access
//   C_incr_small : PPUDATA auto-increment when PPUCTRL[2]=0
package video_vram_types;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} vram_state_t;
  typedef enum logic {GRANT_HOST, GRANT_RND} grant_t;

  localparam int C_incr_small = 1;

endpackage

// File: rtl/video_vaddr.sv
// video_vaddr: PPUADDR two-write latch plus the current VRAM address v.
//   clk, rst   : clock, async active-high reset
//   addr_wr    : host write to PPUADDR, byte on wdata
//   latch_clr  : PPUSTATUS read, clears the write toggle
//   incr       : strobe, advance v by 1 or P_incr_big (incr32)
//   v          : current VRAM address
module video_vaddr
  import video_vram_types::*;
#(
  parameter int P_addr_width = 14,
  parameter int P_incr_big   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    addr_wr,
  input  logic                    latch_clr,
  input  logic [7:0]              wdata,
  input  logic                    incr,
  input  logic                    incr32,
  output logic [P_addr_width-1:0] v
);

  localparam int HI = P_addr_width - 8;

  logic [P_addr_width-1:0] t, t_n, v_n, step;
  logic                    toggle, toggle_n;

  assign step = incr32 ? P_addr_width'(P_incr_big) : P_addr_width'(C_incr_small);

  always_comb begin
    t_n      = t;
    v_n      = v;
    toggle_n = toggle;
    // Increment first so a same-cycle second PPUADDR write overrides it.
    if (incr)
      v_n = v + step;
    if (addr_wr) begin
      if (!toggle) begin
        // High byte: top two bits of the 14-bit space are forced to zero.
        t_n      = {HI'(wdata[5:0]), t[7:0]};
        toggle_n = 1'b1;
      end else begin
        t_n      = {t[P_addr_width-1:8], wdata};
        v_n      = t_n;
        toggle_n = 1'b0;
      end
    end
    // Status read wins over the toggle flip of a same-cycle address write.
    if (latch_clr)
      toggle_n = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t      <= '0;
      v      <= '0;
      toggle <= 1'b0;
    end else begin
      t      <= t_n;
      v      <= v_n;
      toggle <= toggle_n;
    end
  end

endmodule

// File: rtl/video_vram_arbiter.sv
// video_vram_arbiter: shares the 14-bit PPU VRAM bus between the host
// PPUDATA port and the render fetch requester.
//   Host side   : I_addr_wr/I_data_wr/I_data_rd/I_latch_clr pulses, I_host_data,
//                 I_incr32; O_read_buffer (delayed read), O_vaddr, O_overrun, O_busy
//   Render side : I_rnd_req/I_rnd_addr level request; O_rnd_ack/O_rnd_data
//   VRAM side   : O_vid_addr/O_vid_wren/O_vid_data registered, I_vid_data
//                 valid one cycle after the address
// A host access takes IDLE->ACCESS (write) or IDLE->ACCESS->CAPTURE (read).
module video_vram_arbiter
  import video_vram_types::*;
#(
  parameter int P_addr_width = 14,
  parameter int P_incr_big   = 32
) (
  input  logic                    I_clock,
  input  logic                    I_reset,
  input  logic                    I_addr_wr,
  input  logic                    I_data_wr,
  input  logic                    I_data_rd,
  input  logic                    I_latch_clr,
  input  logic [7:0]              I_host_data,
  input  logic                    I_incr32,
  output logic [7:0]              O_read_buffer,
  output logic [P_addr_width-1:0] O_vaddr,
  output logic                    O_overrun,
  output logic                    O_busy,
  input  logic                    I_rnd_req,
  input  logic [P_addr_width-1:0] I_rnd_addr,
  output logic                    O_rnd_ack,
  output logic [7:0]              O_rnd_data,
  output logic [P_addr_width-1:0] O_vid_addr,
  output logic                    O_vid_wren,
  input  logic [7:0]              I_vid_data,
  output logic [7:0]              O_vid_data
);

  logic [P_addr_width-1:0] v;
  logic                    host_req, accept, host_done, host_win, grant_start;
  logic                    pend_vld, pend_wr, host_prio;
  logic [P_addr_width-1:0] pend_addr;
  logic [7:0]              pend_data;
  vram_state_t             state, state_n;
  grant_t                  grant, grant_n;

  // Write wins a same-cycle read: pend_wr takes I_data_wr, the read is dropped.
  assign host_req = I_data_wr | I_data_rd;
  assign accept   = host_req & ~pend_vld;

  video_vaddr #(
    .P_addr_width (P_addr_width),
    .P_incr_big   (P_incr_big)
  ) u_vaddr (
    .clk       (I_clock),
    .rst       (I_reset),
    .addr_wr   (I_addr_wr),
    .latch_clr (I_latch_clr),
    .wdata     (I_host_data),
    .incr      (accept),
    .incr32    (I_incr32),
    .v         (v)
  );

  // Render normally wins; host_prio hands the next slot to a host op that
  // was waiting when a render access finished, so the host cannot starve.
  assign host_win = pend_vld & (host_prio | ~I_rnd_req);

  assign host_done = (grant == GRANT_HOST) &&
                     ((state == ACCESS && pend_wr) || state == CAPTURE);

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    grant_start = 1'b0;
    case (state)
      IDLE: begin
        if (host_win) begin
          state_n     = ACCESS;
          grant_n     = GRANT_HOST;
          grant_start = 1'b1;
        end else if (I_rnd_req) begin
          state_n     = ACCESS;
          grant_n     = GRANT_RND;
          grant_start = 1'b1;
        end
      end
      ACCESS:  state_n = (grant == GRANT_HOST && pend_wr) ? IDLE : CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      state <= IDLE;
      grant <= GRANT_HOST;
    end else begin
      state <= state_n;
      grant <= grant_n;
    end
  end

  // Single-entry host slot; stays valid until its bus access completes.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      pend_vld  <= 1'b0;
      pend_wr   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      O_overrun <= 1'b0;
    end else begin
      O_overrun <= host_req & pend_vld;
      if (accept) begin
        pend_vld  <= 1'b1;
        pend_wr   <= I_data_wr;
        pend_addr <= v;
        pend_data <= I_host_data;
      end else if (host_done) begin
        pend_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      O_vid_addr    <= '0;
      O_vid_wren    <= 1'b0;
      O_vid_data    <= '0;
      O_rnd_ack     <= 1'b0;
      O_read_buffer <= '0;
      host_prio     <= 1'b0;
    end else begin
      O_vid_wren <= 1'b0;
      O_rnd_ack  <= 1'b0;
      if (grant_start) begin
        O_vid_addr <= host_win ? pend_addr : I_rnd_addr;
        O_vid_wren <= host_win & pend_wr;
        O_vid_data <= pend_data;
      end
      // Ack is registered so it lines up with read data in CAPTURE.
      if (state == ACCESS && grant == GRANT_RND)
        O_rnd_ack <= 1'b1;
      if (state == CAPTURE && grant == GRANT_HOST)
        O_read_buffer <= I_vid_data;
      if (state == CAPTURE && grant == GRANT_RND)
        host_prio <= pend_vld | accept;
      else if (grant_start && host_win)
        host_prio <= 1'b0;
    end
  end

  assign O_busy     = pend_vld | (state != IDLE && grant == GRANT_HOST);
  assign O_vaddr    = v;
  assign O_rnd_data = O_rnd_ack ? I_vid_data : 8'h00;

endmodule

// File: tb/tb_video_vram_arbiter.sv
module tb_video_vram_arbiter;

  logic        clk = 1'b0;
  logic        I_reset = 1'b1;
  logic        I_addr_wr = 0, I_data_wr = 0, I_data_rd = 0, I_latch_clr = 0;
  logic [7:0]  I_host_data = 0;
  logic        I_incr32 = 0;
  logic [7:0]  O_read_buffer;
  logic [13:0] O_vaddr;
  logic        O_overrun, O_busy;
  logic        I_rnd_req = 0;
  logic [13:0] I_rnd_addr = 0;
  logic        O_rnd_ack;
  logic [7:0]  O_rnd_data;
  logic [13:0] O_vid_addr;
  logic        O_vid_wren;
  logic [7:0]  I_vid_data;
  logic [7:0]  O_vid_data;

  always #5 clk = ~clk;

  video_vram_arbiter dut (
    .I_clock(clk), .I_reset(I_reset),
    .I_addr_wr(I_addr_wr), .I_data_wr(I_data_wr), .I_data_rd(I_data_rd),
    .I_latch_clr(I_latch_clr), .I_host_data(I_host_data), .I_incr32(I_incr32),
    .O_read_buffer(O_read_buffer), .O_vaddr(O_vaddr), .O_overrun(O_overrun),
    .O_busy(O_busy), .I_rnd_req(I_rnd_req), .I_rnd_addr(I_rnd_addr),
    .O_rnd_ack(O_rnd_ack), .O_rnd_data(O_rnd_data), .O_vid_addr(O_vid_addr),
    .O_vid_wren(O_vid_wren), .I_vid_data(I_vid_data), .O_vid_data(O_vid_data)
  );

  // Synchronous VRAM model, one-cycle read latency
  logic [7:0] mem [0:16383];
  logic [7:0] vid_q;
  always @(posedge clk) begin
    if (O_vid_wren) mem[O_vid_addr] <= O_vid_data;
    vid_q <= mem[O_vid_addr];
  end
  assign I_vid_data = vid_q;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [13:0] a; logic [7:0] d; int c; } wr_t;
  wr_t        wr_exp[$];
  logic [7:0] rnd_exp[$];

  // Scoreboard: every VRAM write and every render ack must be expected
  always @(negedge clk) begin
    if (!I_reset) begin
      if (O_vid_wren) begin
        tests++;
        if (wr_exp.size() == 0) begin
          fails++;
          $display("FAIL vid_write: unexpected write addr=%h data=%h cyc=%0d", O_vid_addr, O_vid_data, cyc);
        end else begin
          wr_t e;
          e = wr_exp.pop_front();
          if (O_vid_addr !== e.a || O_vid_data !== e.d || cyc != e.c) begin
            fails++;
            $display("FAIL vid_write: got %h/%h@%0d want %h/%h@%0d", O_vid_addr, O_vid_data, cyc, e.a, e.d, e.c);
          end
        end
      end
      if (O_rnd_ack) begin
        tests++;
        if (rnd_exp.size() == 0) begin
          fails++;
          $display("FAIL rnd_ack: unexpected ack data=%h cyc=%0d", O_rnd_data, cyc);
        end else begin
          logic [7:0] d;
          d = rnd_exp.pop_front();
          if (O_rnd_data !== d) begin
            fails++;
            $display("FAIL rnd_data: got %h want %h", O_rnd_data, d);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_addr(input logic [7:0] d);
    I_addr_wr = 1; I_host_data = d; tick; I_addr_wr = 0;
  endtask

  task automatic set_v(input logic [13:0] a);
    pulse_addr({2'b00, a[13:8]});
    pulse_addr(a[7:0]);
  endtask

  task automatic host_write(input logic [13:0] a, input logic [7:0] d);
    wr_exp.push_back('{a, d, cyc + 2});
    I_data_wr = 1; I_host_data = d; tick; I_data_wr = 0;
  endtask

  task automatic host_read;
    I_data_rd = 1; tick; I_data_rd = 0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (O_busy && n < 30) begin tick; n++; end
    tests++;
    if (O_busy) begin fails++; $display("FAIL idle_timeout: busy=%b want 0", O_busy); end
  endtask

  task automatic chk_v(input string nm, input logic [13:0] want);
    tests++;
    if (O_vaddr !== want) begin fails++; $display("FAIL %s: vaddr=%h want %h", nm, O_vaddr, want); end
  endtask

  task automatic chk_mem(input string nm, input logic [13:0] a, input logic [7:0] want);
    tests++;
    if (mem[a] !== want) begin fails++; $display("FAIL %s: mem[%h]=%h want %h", nm, a, mem[a], want); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({O_vaddr, O_busy, O_vid_wren, O_rnd_ack, O_vid_addr, O_read_buffer, O_overrun, O_vid_data} !== '0) begin
      fails++;
      $display("FAIL reset_state: vaddr=%h busy=%b wren=%b ack=%b vid_addr=%h buf=%h ovr=%b want all 0",
               O_vaddr, O_busy, O_vid_wren, O_rnd_ack, O_vid_addr, O_read_buffer, O_overrun);
    end
    @(posedge clk); #1; I_reset = 0;
  endtask

  task automatic test_addr_latch;
    pulse_addr(8'h21); chk_v("latch_first", 14'h0000);
    pulse_addr(8'h08); chk_v("latch_pair", 14'h2108);
    pulse_addr(8'h3F); chk_v("latch_hi_only", 14'h2108);
    I_latch_clr = 1; tick; I_latch_clr = 0;
    pulse_addr(8'h20); chk_v("latch_after_clr", 14'h2108);
    pulse_addr(8'h00); chk_v("latch_t_hi", 14'h2000);
  endtask

  task automatic test_write;
    I_incr32 = 0;
    host_write(14'h2000, 8'hA5); chk_v("wr_incr1", 14'h2001);
    wait_idle; chk_mem("wr_mem", 14'h2000, 8'hA5);
    set_v(14'h2000); I_incr32 = 1;
    host_write(14'h2000, 8'h11); chk_v("wr_incr32", 14'h2020);
    wait_idle; I_incr32 = 0;
    set_v(14'h3FFF);
    host_write(14'h3FFF, 8'h66); chk_v("wr_wrap", 14'h0000);
    wait_idle; chk_mem("wr_wrap_mem", 14'h3FFF, 8'h66);
    // contents used by later scenarios
    set_v(14'h0100); host_write(14'h0100, 8'hC3); wait_idle;
    set_v(14'h2001); host_write(14'h2001, 8'h5A); wait_idle;
    set_v(14'h0010); host_write(14'h0010, 8'h77); wait_idle;
    set_v(14'h0020); host_write(14'h0020, 8'hE1); wait_idle;
    set_v(14'h0400); host_write(14'h0400, 8'hD2); wait_idle;
    host_write(14'h0401, 8'hD3); wait_idle;
    set_v(14'h0500); host_write(14'h0500, 8'h11); wait_idle;
  endtask

  task automatic test_read;
    logic [7:0] old;
    set_v(14'h0100); host_read; wait_idle;
    tests++;
    if (O_read_buffer !== 8'hC3) begin fails++; $display("FAIL rd_first: buf=%h want c3", O_read_buffer); end
    set_v(14'h2001);
    old = O_read_buffer;
    host_read; chk_v("rd_incr", 14'h2002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (O_read_buffer !== old) begin fails++; $display("FAIL rd_hold%0d: buf=%h want %h", i, O_read_buffer, old); end
      @(posedge clk);
    end
    @(negedge clk);
    tests++;
    if (O_read_buffer !== 8'h5A) begin fails++; $display("FAIL rd_update: buf=%h want 5a", O_read_buffer); end
    tick; wait_idle;
  endtask

  task automatic test_render_host;
    set_v(14'h0300);
    I_rnd_req = 1; I_rnd_addr = 14'h0010; rnd_exp.push_back(8'h77);
    tick;
    wr_exp.push_back('{14'h0300, 8'h3C, cyc + 3});
    I_data_wr = 1; I_host_data = 8'h3C; tick; I_data_wr = 0;
    @(negedge clk);
    tests++;
    if (O_rnd_ack !== 1'b1) begin fails++; $display("FAIL rh_ack: ack=%b want 1", O_rnd_ack); end
    tests++;
    if (O_overrun !== 1'b0) begin fails++; $display("FAIL rh_no_ovr: ovr=%b want 0", O_overrun); end
    tests++;
    if (O_busy !== 1'b1) begin fails++; $display("FAIL rh_busy: busy=%b want 1", O_busy); end
    tick; I_rnd_req = 0;
    I_data_wr = 1; I_host_data = 8'h99; tick; I_data_wr = 0;
    @(negedge clk);
    tests++;
    if (O_overrun !== 1'b1) begin fails++; $display("FAIL rh_ovr: ovr=%b want 1", O_overrun); end
    chk_v("rh_v_hold", 14'h0301);
    tick;
    @(negedge clk);
    tests++;
    if (O_overrun !== 1'b0) begin fails++; $display("FAIL rh_ovr_pulse: ovr=%b want 0", O_overrun); end
    tick; wait_idle; repeat (3) tick;
    chk_mem("rh_mem", 14'h0300, 8'h3C);
  endtask

  task automatic test_alternate;
    int         ev_log[$];
    int         ack_cyc[$];
    logic [7:0] buf_exp[$];
    logic [7:0] prev;
    int         reads = 0, acks = 0;
    int         want_log[5] = '{1, 2, 1, 2, 1};
    set_v(14'h0400);
    buf_exp.push_back(8'hD2); buf_exp.push_back(8'hD3);
    repeat (3) rnd_exp.push_back(8'hE1);
    prev = O_read_buffer;
    I_rnd_req = 1; I_rnd_addr = 14'h0020;
    for (int i = 0; i < 60 && acks < 3; i++) begin
      I_data_rd = (reads < 2) && !O_busy;
      if (I_data_rd) reads++;
      @(negedge clk);
      if (O_rnd_ack) begin ev_log.push_back(1); acks++; ack_cyc.push_back(cyc); end
      if (O_read_buffer !== prev) begin
        ev_log.push_back(2);
        prev = O_read_buffer;
        tests++;
        if (buf_exp.size() == 0 || O_read_buffer !== buf_exp[0]) begin
          fails++; $display("FAIL alt_buf: buf=%h unexpected", O_read_buffer);
        end
        if (buf_exp.size() != 0) void'(buf_exp.pop_front());
      end
      @(posedge clk); #1;
      if (acks == 3) I_rnd_req = 0;
    end
    I_data_rd = 0; I_rnd_req = 0;
    tests++;
    if (ev_log.size() != 5) begin
      fails++; $display("FAIL alt_events: count=%0d want 5", ev_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (ev_log[k] != want_log[k]) begin
          fails++; $display("FAIL alt_order%0d: event=%0d want %0d", k, ev_log[k], want_log[k]);
        end
      end
    end
    if (ack_cyc.size() == 3) begin
      tests++;
      if (ack_cyc[1] - ack_cyc[0] != 6 || ack_cyc[2] - ack_cyc[1] != 6) begin
        fails++; $display("FAIL alt_spacing: gaps=%0d,%0d want 6,6", ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
      end
    end
    wait_idle; repeat (4) tick;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    set_v(14'h0500);
    host_write(14'h0500, 8'h42);
    @(negedge clk);
    while (!O_vid_wren && n < 10) begin @(negedge clk); n++; end
    tests++;
    if (!O_vid_wren) begin fails++; $display("FAIL rm_wren_seen: wren=%b want 1", O_vid_wren); end
    #1 I_reset = 1;
    #1;
    tests++;
    if ({O_vid_wren, O_vid_addr, O_vid_data, O_rnd_ack, O_rnd_data, O_busy, O_vaddr, O_read_buffer, O_overrun} !== '0) begin
      fails++;
      $display("FAIL rm_outputs: wren=%b addr=%h data=%h ack=%b busy=%b vaddr=%h buf=%h want all 0",
               O_vid_wren, O_vid_addr, O_vid_data, O_rnd_ack, O_busy, O_vaddr, O_read_buffer);
    end
    repeat (2) @(posedge clk); #1 I_reset = 0;
    repeat (5) tick;
    tests++;
    if (O_busy !== 1'b0) begin fails++; $display("FAIL rm_busy: busy=%b want 0", O_busy); end
    chk_mem("rm_aborted", 14'h0500, 8'h11);
  endtask

  initial begin
    test_reset;
    test_addr_latch;
    test_write;
    test_read;
    test_render_host;
    test_alternate;
    test_reset_mid;
    tests++;
    if (wr_exp.size() != 0 || rnd_exp.size() != 0) begin
      fails++; $display("FAIL leftovers: writes=%0d acks=%0d want 0,0", wr_exp.size(), rnd_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time limit reached");
    $fatal(1);
  end

endmodule
